// File: rtl/jtcps1_sdram_arb_if.sv
// rtl/jtcps1_sdram_arb_if.sv - one-word request channel between a requester and a memory port
// Ports (signals):
//   cs    request / chip select, held until ok
//   addr  word address
//   we    1 = write
//   dsn   byte strobes {UDSn,LDSn}, active low
//   din   write data (requester -> memory)
//   dout  read data (memory -> requester), valid with ok
//   ok    one-cycle completion pulse
// Modports: master = side issuing the request, slave = side serving it.
interface jtcps1_sdram_arb_if #(
  parameter int AW = 17
);
  logic          cs;
  logic [AW-1:0] addr;
  logic          we;
  logic [1:0]    dsn;
  logic [15:0]   din;
  logic [15:0]   dout;
  logic          ok;

  modport master (
    output cs, addr, we, dsn, din,
    input  dout, ok
  );

  modport slave (
    input  cs, addr, we, dsn, din,
    output dout, ok
  );
endinterface

// File: rtl/jtcps1_sdram_arb.sv
// rtl/jtcps1_sdram_arb.sv - CPU/video-DMA arbiter for the main-CPU SDRAM port
// Ports:
//   clk, rstn   system clock, asynchronous active-low reset
//   cpu         slave channel from the 68000 bus decoder (cs held for the bus cycle)
//   dma_req     DMA wants a read word; dma_addr advances the cycle after dma_ok
//   dma_dout    DMA read data, valid with dma_ok (one-cycle pulse)
//   dma_grant   high while a DMA word is in flight
//   mem         master channel to the SDRAM multiplexer (registered request)
// One word is served per grant. Ties alternate CPU/DMA; run counts consecutive
// DMA words and forces a CPU grant once it reaches DMA_BURST.
module jtcps1_sdram_arb #(
  parameter int DMA_BURST = 8,
  parameter int AW        = 17
) (
  input  logic               clk,
  input  logic               rstn,
  jtcps1_sdram_arb_if.slave  cpu,
  input  logic               dma_req,
  input  logic [AW-1:0]      dma_addr,
  output logic [15:0]        dma_dout,
  output logic               dma_ok,
  output logic               dma_grant,
  jtcps1_sdram_arb_if.master mem
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_DMA  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam logic       LAST_CPU = 1'b0;
  localparam logic       LAST_DMA = 1'b1;
  localparam logic [3:0] BURST    = 4'(DMA_BURST);

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [3:0]    run_q, run_d;
  logic          cpu_done_q, cpu_done_d;
  logic          mem_cs_q, mem_cs_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_we_q, mem_we_d;
  logic [1:0]    mem_dsn_q, mem_dsn_d;
  logic [15:0]   mem_din_q, mem_din_d;
  logic [15:0]   cpu_dout_q, cpu_dout_d;
  logic          cpu_ok_q, cpu_ok_d;
  logic [15:0]   dma_dout_q, dma_dout_d;
  logic          dma_ok_q, dma_ok_d;
  logic          dma_grant_q, dma_grant_d;

  logic cpu_pend;
  logic cpu_wins;

  // cpu_done blocks a second access inside the same 68000 bus cycle.
  assign cpu_pend = cpu.cs & ~cpu_done_q;
  assign cpu_wins = cpu_pend & (~dma_req | (last_q == LAST_DMA) | (run_q == BURST));

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    run_d       = run_q;
    cpu_done_d  = cpu_done_q;
    mem_cs_d    = mem_cs_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_dsn_d   = mem_dsn_q;
    mem_din_d   = mem_din_q;
    cpu_dout_d  = cpu_dout_q;
    cpu_ok_d    = 1'b0;
    dma_dout_d  = dma_dout_q;
    dma_ok_d    = 1'b0;
    dma_grant_d = dma_grant_q;

    if (!cpu.cs) begin
      cpu_done_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (!dma_req) begin
          run_d = 4'd0;
        end
        if (cpu_wins) begin
          state_d    = ST_CPU;
          mem_cs_d   = 1'b1;
          mem_addr_d = cpu.addr;
          mem_we_d   = cpu.we;
          mem_dsn_d  = cpu.dsn;
          mem_din_d  = cpu.din;
          run_d      = 4'd0;
        end else if (dma_req) begin
          state_d     = ST_DMA;
          mem_cs_d    = 1'b1;
          mem_addr_d  = dma_addr;
          mem_we_d    = 1'b0;
          mem_dsn_d   = 2'b00;
          mem_din_d   = 16'h0000;
          dma_grant_d = 1'b1;
        end
      end
      ST_CPU: begin
        if (mem.ok) begin
          state_d    = ST_GAP;
          cpu_dout_d = mem.dout;
          cpu_ok_d   = 1'b1;
          mem_cs_d   = 1'b0;
          cpu_done_d = 1'b1;   // set wins over the clear above
          last_d     = LAST_CPU;
          run_d      = 4'd0;
        end
      end
      ST_DMA: begin
        if (mem.ok) begin
          state_d     = ST_GAP;
          dma_dout_d  = mem.dout;
          dma_ok_d    = 1'b1;
          mem_cs_d    = 1'b0;
          dma_grant_d = 1'b0;
          last_d      = LAST_DMA;
          run_d       = (run_q == BURST) ? run_q : run_q + 4'd1;
        end
      end
      ST_GAP: begin
        // dead cycle: DMA advances its address, CPU may drop cs
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      last_q      <= LAST_DMA;
      run_q       <= 4'd0;
      cpu_done_q  <= 1'b0;
      mem_cs_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_dsn_q   <= 2'b11;
      mem_din_q   <= 16'h0000;
      cpu_dout_q  <= 16'h0000;
      cpu_ok_q    <= 1'b0;
      dma_dout_q  <= 16'h0000;
      dma_ok_q    <= 1'b0;
      dma_grant_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      run_q       <= run_d;
      cpu_done_q  <= cpu_done_d;
      mem_cs_q    <= mem_cs_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_dsn_q   <= mem_dsn_d;
      mem_din_q   <= mem_din_d;
      cpu_dout_q  <= cpu_dout_d;
      cpu_ok_q    <= cpu_ok_d;
      dma_dout_q  <= dma_dout_d;
      dma_ok_q    <= dma_ok_d;
      dma_grant_q <= dma_grant_d;
    end
  end

  assign mem.cs    = mem_cs_q;
  assign mem.addr  = mem_addr_q;
  assign mem.we    = mem_we_q;
  assign mem.dsn   = mem_dsn_q;
  assign mem.din   = mem_din_q;
  assign cpu.dout  = cpu_dout_q;
  assign cpu.ok    = cpu_ok_q;
  assign dma_dout  = dma_dout_q;
  assign dma_ok    = dma_ok_q;
  assign dma_grant = dma_grant_q;

endmodule

// File: tb/tb_jtcps1_sdram_arb.sv
// tb/tb_jtcps1_sdram_arb.sv - directed self-checking bench for jtcps1_sdram_arb
module tb_jtcps1_sdram_arb;
  localparam int AW        = 17;
  localparam int DMA_BURST = 8;
  localparam int MEM_LAT   = 3;

  logic          clk = 1'b0;
  logic          rstn;
  logic          dma_req;
  logic [AW-1:0] dma_addr;
  logic [15:0]   dma_dout;
  logic          dma_ok;
  logic          dma_grant;

  jtcps1_sdram_arb_if #(.AW(AW)) cpu_if ();
  jtcps1_sdram_arb_if #(.AW(AW)) mem_if ();

  jtcps1_sdram_arb #(.DMA_BURST(DMA_BURST), .AW(AW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cpu       (cpu_if.slave),
    .dma_req   (dma_req),
    .dma_addr  (dma_addr),
    .dma_dout  (dma_dout),
    .dma_ok    (dma_ok),
    .dma_grant (dma_grant),
    .mem       (mem_if.master)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic        fixed_en = 1'b0;
  logic [15:0] fixed_data = 16'h0000;
  logic        spurious_ok = 1'b0;
  bit          grant_log[$];   // 1 = DMA grant, 0 = CPU grant
  int          overlap = 0;
  int          cpu_ok_cnt = 0;
  int          dma_ok_cnt = 0;

  // SDRAM model: mem_ok MEM_LAT clocks after mem_cs, data = fixed or addr ^ 0x5555
  initial begin
    int cnt;
    cnt = 0;
    mem_if.ok   = 1'b0;
    mem_if.dout = 16'h0000;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        cnt = 0;
        mem_if.ok = 1'b0;
      end else if (mem_if.ok) begin
        mem_if.ok = 1'b0;
        cnt = 0;
      end else if (spurious_ok) begin
        mem_if.ok   = 1'b1;
        mem_if.dout = 16'hDEAD;
      end else if (mem_if.cs) begin
        cnt++;
        if (cnt == MEM_LAT) begin
          mem_if.ok   = 1'b1;
          mem_if.dout = fixed_en ? fixed_data : (mem_if.addr[15:0] ^ 16'h5555);
        end
      end
    end
  end

  // DMA engine: advance the address the cycle after each word
  initial begin
    dma_addr = 17'h00100;
    forever begin
      @(negedge clk);
      if (rstn && dma_ok) dma_addr = dma_addr + 17'd1;
    end
  end

  // Monitor: grant order, ok pulse counts, overlap of the two ok pulses
  initial begin
    logic prev_cs;
    prev_cs = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_if.cs && !prev_cs) grant_log.push_back(dma_grant);
      prev_cs = mem_if.cs;
      if (cpu_if.ok && dma_ok) overlap++;
      if (cpu_if.ok) cpu_ok_cnt++;
      if (dma_ok) dma_ok_cnt++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic cpu_idle();
    cpu_if.cs   = 1'b0;
    cpu_if.addr = '0;
    cpu_if.we   = 1'b0;
    cpu_if.dsn  = 2'b11;
    cpu_if.din  = 16'h0000;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    cpu_idle();
    dma_req = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic wait_cpu_ok(input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!cpu_if.ok && n < 40);
    checks++;
    if (!cpu_if.ok) begin
      errors++;
      $display("FAIL %s: cpu_ok got 0 need 1 within 40 clk", tag);
    end
  endtask

  task automatic wait_dma_ok(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!dma_ok && n < 40);
    checks++;
    if (!dma_ok) begin
      errors++;
      $display("FAIL %s: dma_ok got 0 need 1 within 40 clk", tag);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mem_if.cs !== 1'b0) begin errors++; $display("FAIL reset_mem_cs: got %b need 0", mem_if.cs); end
    checks++; if (mem_if.dsn !== 2'b11) begin errors++; $display("FAIL reset_mem_dsn: got %b need 11", mem_if.dsn); end
    checks++; if ({mem_if.we, mem_if.addr, mem_if.din} !== '0) begin errors++; $display("FAIL reset_mem_bus: got we=%b addr=%h din=%h need 0", mem_if.we, mem_if.addr, mem_if.din); end
    checks++; if ({cpu_if.ok, dma_ok, dma_grant} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b need 000", {cpu_if.ok, dma_ok, dma_grant}); end
    checks++; if ({cpu_if.dout, dma_dout} !== 32'h0) begin errors++; $display("FAIL reset_data: got %h need 0", {cpu_if.dout, dma_dout}); end
  endtask

  task automatic test_cpu_read();
    int n;
    int base;
    int oks;
    fixed_en   = 1'b1;
    fixed_data = 16'hBEEF;
    base = grant_log.size();
    cpu_if.cs   = 1'b1;
    cpu_if.addr = 17'h00123;
    cpu_if.we   = 1'b0;
    cpu_if.dsn  = 2'b00;
    tick();
    checks++; if (mem_if.cs !== 1'b1 || mem_if.addr !== 17'h00123) begin errors++; $display("FAIL cpu_grant_latency: got cs=%b addr=%h need cs=1 addr=00123", mem_if.cs, mem_if.addr); end
    wait_cpu_ok("cpu_read_ok", n);
    checks++; if (n !== MEM_LAT) begin errors++; $display("FAIL cpu_ok_latency: got %0d need %0d", n, MEM_LAT); end
    checks++; if (cpu_if.dout !== 16'hBEEF) begin errors++; $display("FAIL cpu_read_data: got %h need BEEF", cpu_if.dout); end
    oks = cpu_ok_cnt;
    tick();
    checks++; if (cpu_if.ok !== 1'b0) begin errors++; $display("FAIL cpu_ok_pulse: got %b need 0", cpu_if.ok); end
    repeat (10) tick();
    checks++; if (grant_log.size() != base + 1 || cpu_ok_cnt != oks) begin errors++; $display("FAIL cpu_no_regrant: got grants=%0d need 1", grant_log.size() - base); end
    cpu_idle();
    fixed_en = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_tie();
    int base;
    int n;
    bit exp_seq[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    base = grant_log.size();
    cpu_if.cs   = 1'b1;
    cpu_if.addr = 17'h00200;
    cpu_if.dsn  = 2'b00;
    dma_req     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_cpu_ok("tie_cpu_ok", n);
      cpu_if.cs = 1'b0;
      if (i == 2) begin
        dma_req = 1'b0;
      end else begin
        tick();
        cpu_if.cs = 1'b1;
      end
    end
    repeat (12) tick();
    checks++;
    if (grant_log.size() < base + 5) begin
      errors++;
      $display("FAIL tie_grant_count: got %0d need >= 5", grant_log.size() - base);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (grant_log[base + i] !== exp_seq[i]) begin
          errors++;
          $display("FAIL tie_order[%0d]: got dma=%b need dma=%b", i, grant_log[base + i], exp_seq[i]);
        end
      end
    end
    cpu_idle();
  endtask

  task automatic test_burst();
    int base;
    int dbase;
    int n;
    int cpu_seen;
    do_reset();
    base  = grant_log.size();
    dbase = dma_ok_cnt;
    dma_req = 1'b1;
    n = 0;
    while (dma_ok_cnt < dbase + 3 && n < 200) begin tick(); n++; end
    n = 0;
    while (!dma_grant && n < 20) begin tick(); n++; end
    checks++; if (!dma_grant || dma_ok_cnt != dbase + 3) begin errors++; $display("FAIL burst_word4_inflight: got grant=%b words=%0d need 1 and 3", dma_grant, dma_ok_cnt - dbase); end
    cpu_if.cs   = 1'b1;
    cpu_if.addr = 17'h00300;
    cpu_if.dsn  = 2'b00;
    wait_cpu_ok("burst_cpu_ok", n);
    checks++; if (dma_ok_cnt - dbase != 4) begin errors++; $display("FAIL burst_cpu_after_word4: got %0d dma words need 4", dma_ok_cnt - dbase); end
    checks++; if (grant_log.size() < base + 5 || grant_log[base + 4] !== 1'b0) begin errors++; $display("FAIL burst_grant4_is_cpu: got log size %0d", grant_log.size() - base); end
    cpu_idle();
    dbase = dma_ok_cnt;
    n = 0;
    while (dma_ok_cnt < dbase + 10 && n < 300) begin tick(); n++; end
    cpu_seen = 0;
    for (int i = base + 5; i < grant_log.size(); i++) if (grant_log[i] == 1'b0) cpu_seen++;
    checks++; if (dma_ok_cnt - dbase < 10 || cpu_seen != 0) begin errors++; $display("FAIL burst_long_stream: got words=%0d cpu=%0d need 10 and 0", dma_ok_cnt - dbase, cpu_seen); end
    dma_req = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_write_and_dma();
    logic [AW-1:0] a;
    int n;
    int base;
    cpu_if.cs   = 1'b1;
    cpu_if.addr = 17'h1FFFF;
    cpu_if.we   = 1'b1;
    cpu_if.dsn  = 2'b01;
    cpu_if.din  = 16'h5A00;
    tick();
    checks++; if ({mem_if.cs, mem_if.we, mem_if.dsn} !== 4'b1101) begin errors++; $display("FAIL wr_ctrl: got cs=%b we=%b dsn=%b need 1 1 01", mem_if.cs, mem_if.we, mem_if.dsn); end
    checks++; if (mem_if.din !== 16'h5A00 || mem_if.addr !== 17'h1FFFF) begin errors++; $display("FAIL wr_bus: got din=%h addr=%h need 5A00 1FFFF", mem_if.din, mem_if.addr); end
    wait_cpu_ok("wr_cpu_ok", n);
    checks++; if (cpu_if.dout !== 16'hAAAA) begin errors++; $display("FAIL wr_capture: got %h need AAAA", cpu_if.dout); end
    cpu_idle();
    tick();
    tick();
    a = dma_addr;
    dma_req = 1'b1;
    tick();
    checks++; if ({mem_if.cs, mem_if.we, mem_if.dsn, dma_grant} !== 5'b10001) begin errors++; $display("FAIL dma_ctrl: got cs=%b we=%b dsn=%b grant=%b need 1 0 00 1", mem_if.cs, mem_if.we, mem_if.dsn, dma_grant); end
    checks++; if (mem_if.addr !== a) begin errors++; $display("FAIL dma_addr: got %h need %h", mem_if.addr, a); end
    dma_req = 1'b0;   // drop mid-word
    base = grant_log.size();
    wait_dma_ok("dma_drop_ok");
    checks++; if (dma_dout !== (a[15:0] ^ 16'h5555)) begin errors++; $display("FAIL dma_data: got %h need %h", dma_dout, a[15:0] ^ 16'h5555); end
    tick();
    checks++; if (dma_ok !== 1'b0 || dma_grant !== 1'b0) begin errors++; $display("FAIL dma_ok_pulse: got ok=%b grant=%b need 0 0", dma_ok, dma_grant); end
    repeat (8) tick();
    checks++; if (grant_log.size() != base || mem_if.cs !== 1'b0) begin errors++; $display("FAIL dma_drop_idle: got %0d new grants need 0", grant_log.size() - base); end
  endtask

  task automatic test_cpu_drop();
    int n;
    cpu_if.cs   = 1'b1;
    cpu_if.addr = 17'h00044;
    cpu_if.dsn  = 2'b00;
    tick();
    cpu_if.cs = 1'b0;
    wait_cpu_ok("cpu_drop_ok", n);
    checks++; if (cpu_if.dout !== 16'h5511) begin errors++; $display("FAIL cpu_drop_data: got %h need 5511", cpu_if.dout); end
    tick();
    cpu_if.cs = 1'b1;
    tick();
    checks++; if (mem_if.cs !== 1'b1 || dma_grant !== 1'b0) begin errors++; $display("FAIL cpu_done_cleared: got cs=%b need 1", mem_if.cs); end
    wait_cpu_ok("cpu_drop_reissue_ok", n);
    cpu_idle();
    tick();
    tick();
  endtask

  task automatic test_spurious_ok();
    int c0;
    int d0;
    c0 = cpu_ok_cnt;
    d0 = dma_ok_cnt;
    spurious_ok = 1'b1;
    tick();
    spurious_ok = 1'b0;
    repeat (3) tick();
    checks++; if (cpu_ok_cnt != c0 || dma_ok_cnt != d0 || mem_if.cs !== 1'b0) begin errors++; $display("FAIL spurious_ok: got cpu_ok=%0d dma_ok=%0d need 0 0", cpu_ok_cnt - c0, dma_ok_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int n;
    int d0;
    dma_req = 1'b1;
    n = 0;
    while (!dma_grant && n < 20) begin tick(); n++; end
    tick();
    #2;
    rstn = 1'b0;
    #1;
    checks++; if ({mem_if.cs, dma_grant, mem_if.dsn} !== 4'b0011 || mem_if.addr !== '0) begin errors++; $display("FAIL async_reset: got cs=%b grant=%b dsn=%b addr=%h need 0 0 11 0", mem_if.cs, dma_grant, mem_if.dsn, mem_if.addr); end
    d0 = dma_ok_cnt;
    cpu_if.cs   = 1'b1;
    cpu_if.addr = 17'h00055;
    cpu_if.dsn  = 2'b00;
    repeat (4) tick();
    checks++; if (dma_ok_cnt != d0) begin errors++; $display("FAIL reset_no_dma_ok: got %0d pulses need 0", dma_ok_cnt - d0); end
    rstn = 1'b1;
    tick();
    checks++; if (mem_if.cs !== 1'b1 || dma_grant !== 1'b0 || mem_if.addr !== 17'h00055) begin errors++; $display("FAIL reset_first_tie_cpu: got cs=%b grant=%b addr=%h need 1 0 00055", mem_if.cs, dma_grant, mem_if.addr); end
    wait_cpu_ok("reset_cpu_ok", n);
    cpu_idle();
    wait_dma_ok("reset_dma_ok");
    dma_req = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    rstn = 1'b0;
    dma_req = 1'b0;
    cpu_idle();
    test_reset();
    test_cpu_read();
    test_tie();
    test_burst();
    test_write_and_dma();
    test_cpu_drop();
    test_spurious_ok();
    test_reset_mid();
    checks++; if (overlap != 0) begin errors++; $display("FAIL ok_overlap: got %0d cycles need 0", overlap); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/jtcps1_sdram_arb.md
Name: jtcps1_sdram_arb

Overview:
- Two-requester arbiter sharing the main-CPU SDRAM port (work RAM + VRAM region, 17-bit word address) between the 68000 bus and the video DMA engine.
- Sits between the CPU bus decoder/DTACK logic and the SDRAM multiplexer.
- Serves one word per grant.
- Alternates CPU and DMA grants under contention, and lets DMA stream up to DMA_BURST words back-to-back before a waiting CPU access is forced in.

Parameters:
- DMA_BURST, 8: maximum consecutive DMA words while cpu_cs is pending (1..15).
- AW, 17: word address width.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- cpu_cs  in  1  CPU RAM/VRAM select; held for the whole bus cycle
- cpu_addr  in  AW  CPU word address
- cpu_we  in  1  1 = write
- cpu_dsn  in  2  byte strobes {UDSn,LDSn}, active low
- cpu_din  in  16  write data
- cpu_dout  out  16  read data, valid with cpu_ok
- cpu_ok  out  1  one-cycle completion pulse
- dma_req  in  1  DMA wants a read word
- dma_addr  in  AW  DMA word address; must advance in the cycle after dma_ok
- dma_dout  out  16  read data, valid with dma_ok
- dma_ok  out  1  one-cycle completion pulse
- dma_grant  out  1  high while the DMA word is in flight
- mem_cs  out  1  request to SDRAM mux
- mem_addr  out  AW  registered address
- mem_we  out  1  registered write enable
- mem_dsn  out  2  registered byte strobes; 2'b00 for DMA
- mem_din  out  16  registered write data
- mem_dout  in  16  SDRAM read data
- mem_ok  in  1  SDRAM completion, one cycle

Behaviour:
- Reset, asynchronous on rstn low:
  - All outputs 0, except mem_dsn = 2'b11.
  - FSM in IDLE.
  - last = DMA, so the CPU wins the first tie.
  - run = 0, cpu_done = 0.
  - Reset mid-transfer aborts silently; no ok pulse is produced.
- States: IDLE, CPU, DMA, GAP.
- IDLE:
  - cpu_pend = cpu_cs & ~cpu_done.
  - Both pending: go to CPU if last == DMA or run == DMA_BURST; otherwise go to DMA.
  - Only one pending: serve it.
  - None pending: stay in IDLE and clear run.
  - On entering CPU or DMA: register addr/we/dsn/din into mem_* and set mem_cs = 1 in the same edge.
  - Grant latency: 1 clk from request to mem_cs.
- CPU:
  - mem_cs held until mem_ok.
  - On mem_ok: cpu_dout <= mem_dout (writes also capture it), cpu_ok = 1 for one cycle, mem_cs = 0, cpu_done = 1, last = CPU, run = 0. Go to GAP.
- DMA:
  - dma_grant = 1 and mem_we = 0 throughout.
  - On mem_ok: dma_dout <= mem_dout, dma_ok = 1 for one cycle, mem_cs = 0, last = DMA, run = run + 1 (saturates at DMA_BURST). Go to GAP.
- GAP:
  - One dead cycle so the DMA can update dma_addr and the CPU can drop cpu_cs. Then go to IDLE.
  - Back-to-back word period is therefore mem latency + 2 clk.
- cpu_done:
  - Cleared only while cpu_cs = 0.
  - Prevents a second access within one 68000 bus cycle.
  - cpu_cs rising while cpu_done = 1 and cpu_cs never went low is not served.
- run is cleared whenever dma_req = 0 in IDLE, or on any CPU grant.
- dma_req dropping while in DMA does not cancel the transfer; the word completes and dma_ok still pulses.
- cpu_cs dropping while in CPU does not cancel either; cpu_ok still pulses and cpu_done then clears in the next cycle.
- mem_ok outside CPU/DMA states is ignored.
- cpu_ok and dma_ok are never high in the same cycle.

Test Plan:
- Reset, then cpu_cs = 1, addr = 0x00123, read; mem_ok after 3 clk with mem_dout = 0xBEEF -> mem_cs rises 1 clk after cpu_cs, cpu_dout = 0xBEEF, cpu_ok is a single pulse, no second mem_cs while cpu_cs stays high.
- cpu_cs and dma_req asserted together from reset -> CPU served first, then DMA. With both held, grants stay CPU/DMA/CPU/DMA as long as run < DMA_BURST.
- DMA_BURST = 8: dma_req held and cpu_cs asserted after DMA word 3 -> CPU served after DMA word 4 (alternation). With cpu_cs asserted while DMA is continuous and last = DMA... the alternation rule applies first; run = 8 forces a CPU grant before a 9th consecutive DMA word.
- CPU write: cpu_we = 1, cpu_dsn = 2'b01, cpu_din = 0x5A00 -> mem_we = 1, mem_dsn = 2'b01, mem_din = 0x5A00. DMA access -> mem_we = 0, mem_dsn = 2'b00.
- Drop dma_req mid-DMA word -> dma_ok still pulses, FSM returns to IDLE via GAP, run = 0.
- Assert rstn = 0 while in DMA with mem_cs = 1 -> all outputs go to reset values asynchronously, no dma_ok pulse; after release, the first tie is granted to the CPU.
